// File: rtl/quad_delta_pkg.sv
// Shared definitions for the quadrature-count delta block: default widths,
// handshake FSM encoding and saturation-limit helpers.
package quad_delta_pkg;

  localparam int unsigned CNT_W_DEF = 4;
  localparam int unsigned ACC_W_DEF = 8;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_t;

  // Signed accumulator limits for a w-bit two's-complement value.
  function automatic int sat_max(input int unsigned w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int sat_min(input int unsigned w);
    return -(1 << (w - 1));
  endfunction

endpackage

// File: rtl/quad_delta_if.sv
// Host read port of quad_delta: four-phase rd_req/rd_ack with a delta snapshot.
interface quad_delta_if
  import quad_delta_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF
) ();

  logic             rd_req;
  logic             rd_ack;
  logic [ACC_W-1:0] rd_data;
  logic             rd_ovf;

  modport master (output rd_req, input rd_ack, input rd_data, input rd_ovf);
  modport slave  (input rd_req, output rd_ack, output rd_data, output rd_ovf);

endinterface

// File: rtl/qdelta_sat_add.sv
// ACC_W-bit signed add of a sign-extended CNT_W-bit delta; saturates and flags
// overflow when QUAD_DELTA_SAT_EN is defined, otherwise wraps with ovf_c=0.
module qdelta_sat_add
  import quad_delta_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0] a,
  input  logic [CNT_W-1:0] d,
  output logic [ACC_W-1:0] sum_c,
  output logic             ovf_c
);

  logic [ACC_W-1:0] d_ext;
  logic [ACC_W-1:0] raw;

  assign d_ext = {{(ACC_W - CNT_W){d[CNT_W-1]}}, d};
  assign raw   = a + d_ext;

`ifdef QUAD_DELTA_SAT_EN
  localparam logic [ACC_W-1:0] SAT_HI = ACC_W'(sat_max(ACC_W));
  localparam logic [ACC_W-1:0] SAT_LO = ACC_W'(sat_min(ACC_W));

  // Overflow only when both operands share a sign the result does not.
  assign ovf_c = (a[ACC_W-1] == d_ext[ACC_W-1]) && (raw[ACC_W-1] != a[ACC_W-1]);
  assign sum_c = ovf_c ? (a[ACC_W-1] ? SAT_LO : SAT_HI) : raw;
`else
  assign ovf_c = 1'b0;
  assign sum_c = raw;
`endif

endmodule

// File: rtl/quad_delta.sv
// Turns the quadrature timer's wrap-around position count into a signed delta
// accumulated between host reads; optional saturation via QUAD_DELTA_SAT_EN.
module quad_delta
  import quad_delta_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ena,
  input  logic [CNT_W-1:0] cnt,
  quad_delta_if.slave      bus
);

  state_t           state, state_nx;
  logic [CNT_W-1:0] prev, prev_nx;
  logic [CNT_W-1:0] delta_c;
  logic             primed, primed_nx;
  logic [ACC_W-1:0] acc, acc_nx;
  logic [ACC_W-1:0] sum_c;
  logic             add_ovf_c;
  logic             rd_ack_q, rd_ack_nx;
  logic [ACC_W-1:0] rd_data_q, rd_data_nx;
  logic             rd_ovf_q, rd_ovf_nx;
`ifdef QUAD_DELTA_SAT_EN
  logic             ovf_acc, ovf_acc_nx;
`endif

  // Modular difference; zero until prev holds a real sample.
  assign delta_c = (ena && primed) ? CNT_W'(cnt - prev) : '0;

  qdelta_sat_add #(
    .CNT_W (CNT_W),
    .ACC_W (ACC_W)
  ) u_add (
    .a     (acc),
    .d     (delta_c),
    .sum_c (sum_c),
    .ovf_c (add_ovf_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev      <= '0;
      primed    <= 1'b0;
      acc       <= '0;
      rd_ack_q  <= 1'b0;
      rd_data_q <= '0;
      rd_ovf_q  <= 1'b0;
`ifdef QUAD_DELTA_SAT_EN
      ovf_acc   <= 1'b0;
`endif
    end else begin
      prev      <= prev_nx;
      primed    <= primed_nx;
      acc       <= acc_nx;
      rd_ack_q  <= rd_ack_nx;
      rd_data_q <= rd_data_nx;
      rd_ovf_q  <= rd_ovf_nx;
`ifdef QUAD_DELTA_SAT_EN
      ovf_acc   <= ovf_acc_nx;
`endif
    end
  end

  always_comb begin
    state_nx   = state;
    prev_nx    = prev;
    primed_nx  = primed;
    acc_nx     = sum_c;
    rd_ack_nx  = rd_ack_q;
    rd_data_nx = rd_data_q;
    rd_ovf_nx  = rd_ovf_q;
`ifdef QUAD_DELTA_SAT_EN
    ovf_acc_nx = ovf_acc | add_ovf_c;
`endif

    if (ena) begin
      prev_nx   = cnt;
      primed_nx = 1'b1;
    end

    case (state)
      IDLE: begin
        // Snapshot includes this cycle's delta; accumulator restarts at zero.
        if (bus.rd_req) begin
          rd_data_nx = sum_c;
`ifdef QUAD_DELTA_SAT_EN
          rd_ovf_nx  = ovf_acc | add_ovf_c;
          ovf_acc_nx = 1'b0;
`else
          rd_ovf_nx  = add_ovf_c;
`endif
          acc_nx     = '0;
          rd_ack_nx  = 1'b1;
          state_nx   = ACK;
        end
      end
      ACK: begin
        if (!bus.rd_req) begin
          rd_ack_nx = 1'b0;
          state_nx  = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.rd_ack  = rd_ack_q;
  assign bus.rd_data = rd_data_q;
  assign bus.rd_ovf  = rd_ovf_q;

endmodule
